// File: rtl/dma85_ctrl.sv
// dma85_ctrl: single-channel block-copy DMA controller for the core85 bus.
//
// Gets the bus from the core through HOLD/HLDA. It then copies a block from
// memory to memory, one byte at a time. Each byte is one read cycle and one
// write cycle, using core85-style multiplexed bus timing. The bus goes back to
// the CPU every BURST bytes; BURST=0 keeps it until the block is finished.
//
// Ports:
//   clk, rst_            clock and asynchronous active-low reset
//   src, dst, count      transfer setup, captured when start is accepted
//   start, stop          begin a transfer / end it after the current byte
//   busy, done, remain   transfer status and bytes still to copy
//   hold, hlda           bus request to the core and grant from the core
//   ready                memory ready; low stretches RT2/WT2
//   ad_in, ad_out, ad_oe multiplexed address/data byte
//   addr_hi, bus_oe      upper address, enable for addr_hi and strobes
//   ale, rd_, wr_, iom_  bus cycle strobes (iom_ is held low)
module dma85_ctrl #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 16,
    parameter int BURST    = 16
) (
    input  logic                         clk,
    input  logic                         rst_,
    input  logic [ADDRSIZE-1:0]          src,
    input  logic [ADDRSIZE-1:0]          dst,
    input  logic [15:0]                  count,
    input  logic                         start,
    input  logic                         stop,
    output logic                         busy,
    output logic                         done,
    output logic [15:0]                  remain,
    output logic                         hold,
    input  logic                         hlda,
    input  logic                         ready,
    input  logic [DATASIZE-1:0]          ad_in,
    output logic [DATASIZE-1:0]          ad_out,
    output logic                         ad_oe,
    output logic [ADDRSIZE-DATASIZE-1:0] addr_hi,
    output logic                         bus_oe,
    output logic                         ale,
    output logic                         rd_,
    output logic                         wr_,
    output logic                         iom_
);

    typedef enum logic [3:0] {
        IDLE, REQ, RT1, RT2, RT3, WT1, WT2, WT3, NEXT, REL, DONE
    } state_t;

    localparam logic [31:0] BURST_N = BURST;

    state_t              state_q, state_d;
    logic [ADDRSIZE-1:0] src_q, src_d;
    logic [ADDRSIZE-1:0] dst_q, dst_d;
    logic [15:0]         remain_q, remain_d;
    logic [15:0]         tenure_q, tenure_d;   // bytes moved in this HOLD tenure
    logic [DATASIZE-1:0] temp_q, temp_d;
    logic                fin_q, fin_d;        // REL ends the transfer rather than re-requesting
    logic                owned;
    logic [15:0]         remain_dec;
    logic [15:0]         tenure_inc;

    function automatic logic burst_full(input logic [15:0] n);
        burst_full = (BURST_N != 32'd0) && (32'(n) == BURST_N);
    endfunction

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q  <= IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            remain_q <= '0;
            tenure_q <= '0;
            temp_q   <= '0;
            fin_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            remain_q <= remain_d;
            tenure_q <= tenure_d;
            temp_q   <= temp_d;
            fin_q    <= fin_d;
        end
    end

    assign owned = state_q inside {RT1, RT2, RT3, WT1, WT2, WT3, NEXT};

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        remain_d   = remain_q;
        tenure_d   = tenure_q;
        temp_d     = temp_q;
        fin_d      = fin_q;
        remain_dec = remain_q - 16'd1;
        tenure_inc = tenure_q + 16'd1;
        if (owned && !hlda) begin
            // Grant lost while we own the bus. Drop the byte in progress and
            // ask again. The pointers move only when a byte completes, so the
            // retry starts at the same byte.
            state_d = REQ;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        src_d    = src;
                        dst_d    = dst;
                        remain_d = count;
                        state_d  = (count != 16'd0) ? REQ : DONE;
                    end
                end
                REQ: begin
                    if (stop) begin
                        state_d = DONE;
                    end else if (hlda) begin
                        tenure_d = '0;
                        state_d  = RT1;
                    end
                end
                RT1: state_d = RT2;
                RT2: if (ready) state_d = RT3;
                RT3: begin
                    temp_d  = ad_in;
                    state_d = WT1;
                end
                WT1: state_d = WT2;
                WT2: if (ready) state_d = WT3;
                WT3: begin
                    src_d    = src_q + 1'b1;
                    dst_d    = dst_q + 1'b1;
                    remain_d = remain_dec;
                    tenure_d = tenure_inc;
                    // Within a tenure, go straight from WT3 to RT1. NEXT is
                    // entered only when the tenure or the transfer ends. A
                    // byte therefore takes six clocks with no wait states.
                    if (remain_dec != 16'd0 && !stop && !burst_full(tenure_inc)) begin
                        state_d = RT1;
                    end else begin
                        state_d = NEXT;
                    end
                end
                NEXT: begin
                    if (remain_q == 16'd0 || stop) begin
                        fin_d   = 1'b1;
                        state_d = REL;
                    end else if (burst_full(tenure_q)) begin
                        fin_d   = 1'b0;
                        state_d = REL;
                    end else begin
                        state_d = RT1;
                    end
                end
                REL: begin
                    if (!hlda) state_d = fin_q ? DONE : REQ;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        hold    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        ale     = 1'b0;
        rd_     = 1'b1;
        wr_     = 1'b1;
        ad_oe   = 1'b0;
        bus_oe  = 1'b0;
        ad_out  = '0;
        addr_hi = '0;
        if (owned) begin
            hold   = 1'b1;
            bus_oe = 1'b1;
        end
        case (state_q)
            REQ: begin
                hold = 1'b1;
                busy = 1'b1;
            end
            RT1: begin
                busy    = 1'b1;
                ale     = 1'b1;
                ad_oe   = 1'b1;
                ad_out  = src_q[DATASIZE-1:0];
                addr_hi = src_q[ADDRSIZE-1:DATASIZE];
            end
            RT2, RT3: begin
                busy    = 1'b1;
                rd_     = 1'b0;
                addr_hi = src_q[ADDRSIZE-1:DATASIZE];
            end
            WT1: begin
                busy    = 1'b1;
                ale     = 1'b1;
                ad_oe   = 1'b1;
                ad_out  = dst_q[DATASIZE-1:0];
                addr_hi = dst_q[ADDRSIZE-1:DATASIZE];
            end
            WT2, WT3: begin
                busy    = 1'b1;
                wr_     = 1'b0;
                ad_oe   = 1'b1;
                ad_out  = temp_q;
                addr_hi = dst_q[ADDRSIZE-1:DATASIZE];
            end
            NEXT:    busy = 1'b1;
            REL:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign iom_   = 1'b0;
    assign remain = remain_q;

endmodule

// File: tb/tb_dma85_ctrl.sv
// tb_dma85_ctrl: directed and randomized bench for dma85_ctrl.
// Contains a memory/core model that answers bus cycles and grants the bus two
// clocks after HOLD. It also keeps a reference of the expected copies and
// tenure sizes, built from the source contents before each transfer.
module tb_dma85_ctrl;

    localparam int BURST = 16;

    logic        clk = 1'b0;
    logic        rst_;
    logic [15:0] src, dst, count;
    logic        start, stop;
    logic        busy, done;
    logic [15:0] remain;
    logic        hold;
    logic        hlda  = 1'b0;
    logic        ready = 1'b1;
    logic [7:0]  ad_in = 8'h00;
    logic [7:0]  ad_out;
    logic        ad_oe;
    logic [7:0]  addr_hi;
    logic        bus_oe, ale, rd_, wr_, iom_;

    always #5 clk = ~clk;

    dma85_ctrl #(.DATASIZE(8), .ADDRSIZE(16), .BURST(BURST)) dut (
        .clk(clk), .rst_(rst_), .src(src), .dst(dst), .count(count),
        .start(start), .stop(stop), .busy(busy), .done(done), .remain(remain),
        .hold(hold), .hlda(hlda), .ready(ready), .ad_in(ad_in), .ad_out(ad_out),
        .ad_oe(ad_oe), .addr_hi(addr_hi), .bus_oe(bus_oe), .ale(ale),
        .rd_(rd_), .wr_(wr_), .iom_(iom_)
    );

    // Controls for the bus model, written only by the stimulus block.
    logic       rand_ready;
    int         rd_wait_cfg, wt_wait_cfg;
    logic       kill;
    logic [7:0] seed;

    // Memory and bus observation, written only by the model block.
    logic [7:0]  wmem   [0:65535];
    bit          wvalid [0:65535];
    logic [15:0] lat = 16'h0000;
    logic        h1 = 1'b0, hold_p = 1'b0, rd_p = 1'b1, wr_p = 1'b1;
    int          rd_run = 0, wr_run = 0;
    int          owned_tot = 0, wr_tot = 0, rd_tot = 0, done_tot = 0;
    int          hold_tot = 0, rise_tot = 0, rise_bad = 0, ten_bytes = 0;
    int          tenq [$];
    logic [15:0] rdq  [$];

    function automatic logic [7:0] mem_rd(input logic [15:0] a);
        logic [15:0] m;
        m = a * 16'd37;
        mem_rd = wvalid[a] ? wmem[a] : (m[7:0] ^ a[15:8] ^ seed);
    endfunction

    always @(negedge clk) begin
        if (hold && hlda) owned_tot++;
        if (hold) hold_tot++;
        if (hold && !hold_p) begin
            rise_tot++;
            if (hlda) rise_bad++;
        end
        if (!hold && hold_p && ten_bytes > 0) begin
            tenq.push_back(ten_bytes);
            ten_bytes = 0;
        end
        if (done) done_tot++;
        if (ale) lat = {addr_hi, ad_out};
        if (!rd_ && rd_p) begin
            rdq.push_back(lat);
            rd_tot++;
        end
        if (!wr_ && wr_p) begin
            wr_tot++;
            ten_bytes++;
        end
        if (!wr_) begin
            wmem[lat]   = ad_out;
            wvalid[lat] = 1'b1;
        end
        ad_in  = mem_rd(lat);
        rd_run = rd_ ? 0 : rd_run + 1;
        wr_run = wr_ ? 0 : wr_run + 1;
        if (rand_ready) ready = ($urandom_range(0, 2) != 0);
        else ready = !((!rd_ && rd_run <= rd_wait_cfg) || (!wr_ && wr_run <= wt_wait_cfg));
        hlda   = h1 && !kill;
        h1     = hold;
        hold_p = hold;
        rd_p   = rd_;
        wr_p   = wr_;
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [15:0] s, input logic [15:0] d, input logic [15:0] c);
        src   = s;
        dst   = d;
        count = c;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done), 32'd1);
    endtask

    task automatic copy_check(input string tag, input logic [15:0] s, input logic [15:0] d,
                              input logic [15:0] c, input bit chk_ten);
        logic [7:0] snap [$];
        int exp_ten [$];
        int ten0, wr0, dn0, mism, n, b;
        for (int i = 0; i < int'(c); i++) snap.push_back(mem_rd(s + 16'(i)));
        n = int'(c);
        while (n > 0) begin
            b = (n > BURST) ? BURST : n;
            exp_ten.push_back(b);
            n -= b;
        end
        ten0 = tenq.size();
        wr0  = wr_tot;
        dn0  = done_tot;
        go(s, d, c);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(tag, 3000);
        tick();
        chk({tag, "_done_low"}, 32'(done), 32'd0);
        chk({tag, "_done_pulses"}, 32'(done_tot - dn0), 32'd1);
        chk({tag, "_remain"}, 32'(remain), 32'd0);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
        mism = 0;
        for (int i = 0; i < int'(c); i++)
            if (mem_rd(d + 16'(i)) !== snap[i]) mism++;
        chk({tag, "_data_mismatches"}, 32'(mism), 32'd0);
        if (chk_ten) begin
            chk({tag, "_writes"}, 32'(wr_tot - wr0), 32'(c));
            chk({tag, "_tenures"}, 32'(tenq.size() - ten0), 32'(exp_ten.size()));
            for (int k = 0; k < exp_ten.size() && ten0 + k < tenq.size(); k++)
                chk($sformatf("%s_tenure%0d", tag, k), 32'(tenq[ten0+k]), 32'(exp_ten[k]));
        end
    endtask

    initial begin
        int o0, r0, b0, k0, h0, d0, w0, rr0, n, mism;
        logic [7:0] snap [$];
        logic [15:0] s;
        logic [15:0] c;
        rst_ = 1'b1; start = 1'b0; stop = 1'b0;
        src = '0; dst = '0; count = '0;
        rand_ready = 1'b0; rd_wait_cfg = 0; wt_wait_cfg = 0; kill = 1'b0; seed = 8'h5A;

        // Reset values, observed before any clock edge.
        #2 rst_ = 1'b0;
        #1;
        chk("rst_hold", 32'(hold), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_remain", 32'(remain), 32'd0);
        chk("rst_ale", 32'(ale), 32'd0);
        chk("rst_rd", 32'(rd_), 32'd1);
        chk("rst_wr", 32'(wr_), 32'd1);
        chk("rst_iom", 32'(iom_), 32'd0);
        chk("rst_ad_oe", 32'(ad_oe), 32'd0);
        chk("rst_bus_oe", 32'(bus_oe), 32'd0);
        chk("rst_ad_out", 32'(ad_out), 32'd0);
        chk("rst_addr_hi", 32'(addr_hi), 32'd0);
        repeat (3) tick();
        rst_ = 1'b1;
        repeat (2) tick();

        // Asynchronous reset in the middle of a read cycle.
        go(16'h1000, 16'h5000, 16'd8);
        n = 0;
        while (rd_ !== 1'b0 && n < 20) begin tick(); n++; end
        chk("midrst_read_seen", 32'(rd_), 32'd0);
        #2 rst_ = 1'b0;
        #1;
        chk("midrst_hold", 32'(hold), 32'd0);
        chk("midrst_ad_oe", 32'(ad_oe), 32'd0);
        chk("midrst_bus_oe", 32'(bus_oe), 32'd0);
        chk("midrst_rd", 32'(rd_), 32'd1);
        chk("midrst_wr", 32'(wr_), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        chk("midrst_remain", 32'(remain), 32'd0);
        chk("midrst_hold_held", 32'(hold), 32'd0);
        rst_ = 1'b1;
        repeat (6) tick();

        // Basic copy: 4 bytes with one tenure; the bus is owned 4*6+1 clocks.
        o0 = owned_tot; r0 = rise_tot;
        copy_check("basic", 16'h2000, 16'h3000, 16'd4, 1'b1);
        chk("basic_owned_clocks", 32'(owned_tot - o0), 32'd25);
        chk("basic_hold_rises", 32'(rise_tot - r0), 32'd1);

        // Wait states: three in RT2 and two in WT2 stretch the byte to 11 clocks.
        rd_wait_cfg = 3; wt_wait_cfg = 2;
        o0 = owned_tot;
        copy_check("wait", 16'h2100, 16'h3100, 16'd1, 1'b1);
        chk("wait_byte_clocks", 32'(owned_tot - o0 - 1), 32'd11);
        rd_wait_cfg = 0; wt_wait_cfg = 0;

        // Burst release: 40 bytes as 16+16+8, each re-request after HLDA drops.
        o0 = owned_tot; r0 = rise_tot; b0 = rise_bad;
        copy_check("burst", 16'h4000, 16'hC000, 16'd40, 1'b1);
        chk("burst_hold_rises", 32'(rise_tot - r0), 32'd3);
        chk("burst_rise_with_hlda", 32'(rise_bad - b0), 32'd0);
        chk("burst_owned_clocks", 32'(owned_tot - o0), 32'd243);

        // Source address wraps from FFFF to 0000.
        k0 = rdq.size();
        copy_check("wrap", 16'hFFFF, 16'h6000, 16'd2, 1'b1);
        chk("wrap_reads", 32'(rdq.size() - k0), 32'd2);
        if (rdq.size() >= k0 + 2) begin
            chk("wrap_read0", 32'(rdq[k0]), 32'h0000FFFF);
            chk("wrap_read1", 32'(rdq[k0+1]), 32'h00000000);
        end

        // Zero count: done the cycle after start, hold never raised.
        h0 = hold_tot; d0 = done_tot;
        go(16'h1234, 16'h5678, 16'd0);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        tick();
        chk("zero_done_low", 32'(done), 32'd0);
        chk("zero_hold_cycles", 32'(hold_tot - h0), 32'd0);
        chk("zero_done_pulses", 32'(done_tot - d0), 32'd1);

        // Stop during byte 3 of 10: byte 3 completes, 7 remain.
        snap.delete();
        for (int i = 0; i < 3; i++) snap.push_back(mem_rd(16'h7000 + 16'(i)));
        w0 = wr_tot; d0 = done_tot;
        go(16'h7000, 16'h7800, 16'd10);
        n = 0;
        while (wr_tot - w0 < 3 && n < 100) begin tick(); n++; end
        chk("stop_byte3_reached", 32'(wr_tot - w0), 32'd3);
        stop = 1'b1;
        wait_done("stop", 100);
        stop = 1'b0;
        tick();
        chk("stop_remain", 32'(remain), 32'd7);
        chk("stop_writes", 32'(wr_tot - w0), 32'd3);
        chk("stop_hold", 32'(hold), 32'd0);
        chk("stop_done_pulses", 32'(done_tot - d0), 32'd1);
        mism = 0;
        for (int i = 0; i < 3; i++)
            if (mem_rd(16'h7800 + 16'(i)) !== snap[i]) mism++;
        chk("stop_data_mismatches", 32'(mism), 32'd0);

        // Stop while still waiting for the grant: no bus cycle at all.
        rr0 = rd_tot;
        go(16'h7100, 16'h7900, 16'd5);
        stop = 1'b1;
        tick();
        chk("reqstop_done", 32'(done), 32'd1);
        stop = 1'b0;
        tick();
        chk("reqstop_remain", 32'(remain), 32'd5);
        chk("reqstop_reads", 32'(rd_tot - rr0), 32'd0);
        chk("reqstop_busy", 32'(busy), 32'd0);
        repeat (6) tick();

        // Grant withdrawn mid-transfer: the byte is retried and the copy completes.
        snap.delete();
        for (int i = 0; i < 6; i++) snap.push_back(mem_rd(16'h0800 + 16'(i)));
        w0 = wr_tot; d0 = done_tot;
        go(16'h0800, 16'h0900, 16'd6);
        n = 0;
        while (wr_tot - w0 < 2 && n < 100) begin tick(); n++; end
        kill = 1'b1;
        tick(); tick();
        chk("grantloss_bus_oe", 32'(bus_oe), 32'd0);
        chk("grantloss_hold", 32'(hold), 32'd1);
        kill = 1'b0;
        wait_done("grantloss", 200);
        tick();
        chk("grantloss_remain", 32'(remain), 32'd0);
        chk("grantloss_done_pulses", 32'(done_tot - d0), 32'd1);
        mism = 0;
        for (int i = 0; i < 6; i++)
            if (mem_rd(16'h0900 + 16'(i)) !== snap[i]) mism++;
        chk("grantloss_data_mismatches", 32'(mism), 32'd0);
        repeat (4) tick();

        // Randomized copies with random wait states.
        rand_ready = 1'b1;
        for (int it = 0; it < 5; it++) begin
            s = 16'($urandom);
            c = 16'($urandom_range(1, 40));
            copy_check($sformatf("rand%0d", it), s, s + 16'h8000, c, 1'b1);
            repeat (2) tick();
        end
        rand_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
